alu_sequencer: RTL and testbench
================================

# alu_sequencer

Control-unit FSM that drives the existing `datapath` control inputs to execute one instruction at a time: fetch, decode and execute of register-register ALU operations, unary operations, and the HI/LO multiply/divide path. It replaces hand-timed control waveforms with a cycle-exact Moore sequencer. It sits beside `datapath`, reads the instruction register contents back from it, and handshakes with memory through `mem_ready`.

## Interface
- `NREGS`, 16: general registers; width of the one-hot `rin`/`rout` vectors.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `clr`  in  1  reset, asynchronous, active-low.
- `run`  in  1  permits fetch of the next instruction.
- `mem_ready`  in  1  memory data valid on `Mdatain` this cycle.
- `ir`  in  32  IR contents from the datapath. Opcode is `ir[31:27]`, Ra `ir[26:23]`, Rb `ir[22:19]`, Rc `ir[18:15]`.
- `rin`, `rout`  out  NREGS  one-hot register load and drive enables.
- `PCout PCin incPC MARin MDRin MDRout Read IRin Yin Zin ZLowOut ZHighOut HIin LOin`  out  1 each  datapath strobes.
- `opcode`  out  5  ALU operation select.
- `busy`  out  1  high in every state except IDLE and HALT.
- `halted`  out  1  high in HALT.
- `illegal`  out  1  one-cycle pulse when an undefined opcode is decoded.

## Operation
- Opcodes:
  - Binary: sub 00010, add 00011, and 00100, or 00101, shr 00110, shl 00111, ror 01000, rol 01001.
  - Multiply/divide: mul 01010, div 01011.
  - Unary: neg 01100, not 01101.
  - Other: nop 11010, halt 11011. Any other opcode is undefined.
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT. Outputs are a decode of the state and the latched `ir` fields only (Moore); all unlisted outputs are 0.
- IDLE: no strobes. Go to T0 when `run` = 1.
- T0: PCout, MARin, incPC, Zin. Go to T1.
- T1: ZLowOut, PCin, Read, MDRin, held every cycle while waiting. Go to T2 when `mem_ready` = 1, otherwise stay in T1. Re-asserting is idempotent because Z is stable.
- T2: MDRout, IRin. Go to T3.
- T3 decode, by opcode class:
  - Binary: T3 rout[Rb], Yin. T4 rout[Rc], opcode, Zin. T5 ZLowOut, rin[Ra]. Then to T0/IDLE.
  - Unary: T3 rout[Rb], opcode, Zin. T4 ZLowOut, rin[Ra]. Then to T0/IDLE.
  - mul/div: T3 rout[Ra], Yin. T4 rout[Rb], opcode, Zin. T5 ZLowOut, LOin. T6 ZHighOut, HIin. Then to T0/IDLE.
  - nop: T3 asserts nothing, then to T0/IDLE.
  - Undefined: T3 pulses `illegal` and otherwise behaves as nop.
  - halt: T3 goes to HALT.
- End of instruction: go to T0 if `run` = 1, else IDLE. Dropping `run` never aborts an instruction in progress.
- HALT: `halted` = 1, no strobes. Left only by `clr`.
- `opcode` output is 0 in every state where Zin is not asserted for an execute step. In T0 it is 00011 (add), so the ALU increments PC through Z.
- `rin` and `rout` are always zero or one-hot. Register index equal to NREGS or above cannot occur with NREGS = 16.

## Timing
- Reset (`clr` = 0): state is forced to IDLE immediately, with no wait for `clk`. All outputs go to 0 in the same delta, including `busy`, `halted` and `illegal`. This applies mid-instruction; no partial write completes after reset asserts.
- Reset release: first possible T0 is on the first rising edge with `clr` = 1 and `run` = 1.
- Latency with `mem_ready` already high in T1, counting cycles from T0 to the return to T0:
  - Binary: 6 cycles.
  - Unary: 5 cycles.
  - mul/div: 7 cycles.
  - nop and undefined: 4 cycles.
- Each cycle of `mem_ready` = 0 in T1 adds exactly one cycle.
- `ir` is sampled only in T3 through T6. It is stable from the T2 edge onward because IRin is deasserted after T2.
- Never asserted together in one cycle:
  - two or more `rout` bits;
  - any `rout` bit with ZLowOut, ZHighOut, MDRout or PCout;
  - Read outside T1.
- `busy` is high from entry to T0 until the state returns to IDLE or enters HALT.

## Test plan
- Binary sub: preload R4 = 16, R5 = 32; fetch `ir` = {00010, 0000, 0100, 0101, 15'b0} with `mem_ready` tied high. Required: T3 rout[4]+Yin, T4 rout[5]+opcode 00010+Zin, T5 ZLowOut+rin[0]. R0 = 0xFFFFFFF0 (16 − 32). Next T0 starts 6 cycles after the first T0.
- Memory stall: hold `mem_ready` = 0 for 3 cycles in T1. Required: FSM stays in T1 for 4 cycles with Read, MDRin, PCin high throughout; IRin pulses exactly once; total binary latency 9 cycles.
- mul: R2 = 16, R3 = −2. Required: LOin in T5, HIin in T6. LO = 0xFFFFFFE0, HI = 0xFFFFFFFF. Latency 7 cycles.
- halt, then `run` low: halt opcode gives `halted` = 1, `busy` = 0, no strobes for 20 cycles. With `run` dropped during an add, the add completes through T5 and the FSM then sits in IDLE.
- Undefined opcode 11111: `illegal` is high for exactly 1 cycle (T3), no rin/HIin/LOin asserted, return to T0 after 4 cycles.
- Async reset mid-T4 between clock edges: all outputs are 0 before the next edge, state is IDLE, destination register unchanged.

Source files
------------

// File: rtl/alu_sequencer.sv
// Moore control sequencer for the datapath: fetch, decode and execute of
// binary, unary and HI/LO multiply/divide instructions, one at a time.
module alu_sequencer #(
  parameter int NREGS = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             run,
  input  logic             mem_ready,
  input  logic [31:0]      ir,
  output logic [NREGS-1:0] rin,
  output logic [NREGS-1:0] rout,
  output logic             PCout,
  output logic             PCin,
  output logic             incPC,
  output logic             MARin,
  output logic             MDRin,
  output logic             MDRout,
  output logic             Read,
  output logic             IRin,
  output logic             Yin,
  output logic             Zin,
  output logic             ZLowOut,
  output logic             ZHighOut,
  output logic             HIin,
  output logic             LOin,
  output logic [4:0]       opcode,
  output logic             busy,
  output logic             halted,
  output logic             illegal
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_t;

  state_t state_q, state_d, end_state;

  logic [4:0] ir_op;
  logic [3:0] ra, rb, rc;
  logic       is_binary, is_unary, is_muldiv, is_nop, is_halt;
  logic       unused_ir_bits;

  assign ir_op          = ir[31:27];
  assign ra             = ir[26:23];
  assign rb             = ir[22:19];
  assign rc             = ir[18:15];
  assign unused_ir_bits = ^ir[14:0];

  assign is_binary = (ir_op >= 5'b00010) && (ir_op <= 5'b01001);
  assign is_muldiv = (ir_op == 5'b01010) || (ir_op == 5'b01011);
  assign is_unary  = (ir_op == 5'b01100) || (ir_op == 5'b01101);
  assign is_nop    = (ir_op == 5'b11010);
  assign is_halt   = (ir_op == 5'b11011);

  function automatic logic [NREGS-1:0] onehot(input logic [3:0] idx);
    onehot = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (int'(idx) == i) onehot[i] = 1'b1;
    end
  endfunction

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Dropping run only takes effect at the instruction boundary.
  assign end_state = run ? S_T0 : S_IDLE;

  always_comb begin
    state_d  = state_q;
    rin      = '0;
    rout     = '0;
    PCout    = 1'b0;
    PCin     = 1'b0;
    incPC    = 1'b0;
    MARin    = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    Read     = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zin      = 1'b0;
    ZLowOut  = 1'b0;
    ZHighOut = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    opcode   = 5'b00000;
    illegal  = 1'b0;
    halted   = 1'b0;
    busy     = 1'b1;

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (run) state_d = S_T0;
      end
      S_T0: begin
        PCout   = 1'b1;
        MARin   = 1'b1;
        incPC   = 1'b1;
        Zin     = 1'b1;
        opcode  = 5'b00011;
        state_d = S_T1;
      end
      S_T1: begin
        ZLowOut = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        if (mem_ready) state_d = S_T2;
      end
      S_T2: begin
        MDRout  = 1'b1;
        IRin    = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        if (is_binary) begin
          rout    = onehot(rb);
          Yin     = 1'b1;
          state_d = S_T4;
        end else if (is_unary) begin
          rout    = onehot(rb);
          opcode  = ir_op;
          Zin     = 1'b1;
          state_d = S_T4;
        end else if (is_muldiv) begin
          rout    = onehot(ra);
          Yin     = 1'b1;
          state_d = S_T4;
        end else if (is_halt) begin
          state_d = S_HALT;
        end else begin
          illegal = !is_nop;
          state_d = end_state;
        end
      end
      S_T4: begin
        if (is_binary) begin
          rout    = onehot(rc);
          opcode  = ir_op;
          Zin     = 1'b1;
          state_d = S_T5;
        end else if (is_unary) begin
          ZLowOut = 1'b1;
          rin     = onehot(ra);
          state_d = end_state;
        end else if (is_muldiv) begin
          rout    = onehot(rb);
          opcode  = ir_op;
          Zin     = 1'b1;
          state_d = S_T5;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_T5: begin
        if (is_binary) begin
          ZLowOut = 1'b1;
          rin     = onehot(ra);
          state_d = end_state;
        end else if (is_muldiv) begin
          ZLowOut = 1'b1;
          LOin    = 1'b1;
          state_d = S_T6;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_T6: begin
        ZHighOut = 1'b1;
        HIin     = 1'b1;
        state_d  = end_state;
      end
      S_HALT: begin
        busy   = 1'b0;
        halted = 1'b1;
      end
      default: begin
        busy    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: a small behavioural datapath and memory model
// lets directed instructions run end to end so register results can be checked.
module tb_alu_sequencer;

   localparam logic [13:0] B_PCOUT  = 14'h2000;
   localparam logic [13:0] B_PCIN   = 14'h1000;
   localparam logic [13:0] B_INCPC  = 14'h0800;
   localparam logic [13:0] B_MARIN  = 14'h0400;
   localparam logic [13:0] B_MDRIN  = 14'h0200;
   localparam logic [13:0] B_MDROUT = 14'h0100;
   localparam logic [13:0] B_READ   = 14'h0080;
   localparam logic [13:0] B_IRIN   = 14'h0040;
   localparam logic [13:0] B_YIN    = 14'h0020;
   localparam logic [13:0] B_ZIN    = 14'h0010;
   localparam logic [13:0] B_ZLOW   = 14'h0008;
   localparam logic [13:0] B_ZHIGH  = 14'h0004;
   localparam logic [13:0] B_HIIN   = 14'h0002;
   localparam logic [13:0] B_LOIN   = 14'h0001;
   localparam logic [13:0] T0_PAT   = B_PCOUT | B_MARIN | B_INCPC | B_ZIN;
   localparam logic [13:0] T1_PAT   = B_ZLOW | B_PCIN | B_READ | B_MDRIN;
   localparam logic [13:0] T2_PAT   = B_MDROUT | B_IRIN;

   logic        clk = 1'b0;
   logic        clr;
   logic        run;
   logic        memReady;
   logic [31:0] irReg;
   logic [15:0] rin, rout;
   logic        PCout, PCin, incPC, MARin, MDRin, MDRout, Read, IRin;
   logic        Yin, Zin, ZLowOut, ZHighOut, HIin, LOin;
   logic [4:0]  opcode;
   logic        busy, halted, illegal;

   logic [13:0] strobes;
   logic [53:0] allOut;

   logic [31:0] regs [16];
   logic [31:0] mem [16];
   logic [31:0] pc, mar, mdr, yReg, hiReg, loReg, busVal;
   logic [63:0] zReg, aluVal;
   logic signed [63:0] ySx, bSx;
   logic        preload;

   int checks = 0;
   int failures = 0;

   logic [13:0] logStrobe [32];
   logic [15:0] logRout [32];
   logic [15:0] logRin [32];
   logic [4:0]  logOp [32];
   logic        logIllegal [32];
   int          readCyc, t1Match, irinCnt, illegalCnt, writeCnt, violations;

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   alu_sequencer #(.NREGS(16)) dut (
      .clk(clk), .clr(clr), .run(run), .mem_ready(memReady), .ir(irReg),
      .rin(rin), .rout(rout), .PCout(PCout), .PCin(PCin), .incPC(incPC),
      .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .IRin(IRin),
      .Yin(Yin), .Zin(Zin), .ZLowOut(ZLowOut), .ZHighOut(ZHighOut),
      .HIin(HIin), .LOin(LOin), .opcode(opcode), .busy(busy),
      .halted(halted), .illegal(illegal)
   );

   assign strobes = {PCout, PCin, incPC, MARin, MDRin, MDRout, Read, IRin,
                     Yin, Zin, ZLowOut, ZHighOut, HIin, LOin};
   assign allOut  = {strobes, rin, rout, opcode, busy, halted, illegal};
   assign ySx     = {{32{yReg[31]}}, yReg};
   assign bSx     = {{32{busVal[31]}}, busVal};

   function automatic int oneHotIdx(input logic [15:0] v);
      oneHotIdx = 0;
      for (int i = 0; i < 16; i++) if (v[i]) oneHotIdx = i;
   endfunction

   // Shared bus and ALU of the datapath model, driven by the sequencer strobes.
   always_comb begin
      busVal = 32'h0;
      aluVal = 64'h0;
      if (PCout)             busVal = pc;
      else if (ZLowOut)      busVal = zReg[31:0];
      else if (ZHighOut)     busVal = zReg[63:32];
      else if (MDRout)       busVal = mdr;
      else if (rout != 16'h0) busVal = regs[oneHotIdx(rout)];
      if (incPC) aluVal = {32'h0, busVal + 32'd1};
      else begin
         case (opcode)
            5'b00010: aluVal = {32'h0, yReg - busVal};
            5'b00011: aluVal = {32'h0, yReg + busVal};
            5'b00100: aluVal = {32'h0, yReg & busVal};
            5'b00101: aluVal = {32'h0, yReg | busVal};
            5'b01010: aluVal = ySx * bSx;
            5'b01100: aluVal = {32'h0, 32'h0 - busVal};
            5'b01101: aluVal = {32'h0, ~busVal};
            default:  aluVal = 64'h0;
         endcase
      end
   end

   // Datapath register file and latches; preload seeds the operand registers.
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 16; i++) regs[i] <= 32'h0;
         regs[2] <= 32'd16;
         regs[3] <= 32'hFFFF_FFFE;
         regs[4] <= 32'd16;
         regs[5] <= 32'd32;
         pc    <= 32'h0;
         hiReg <= 32'h0;
         loReg <= 32'h0;
         irReg <= 32'h0;
      end else begin
         if (PCin)  pc <= busVal;
         if (MARin) mar <= busVal;
         if (MDRin && Read) mdr <= mem[mar[3:0]];
         if (IRin)  irReg <= busVal;
         if (Yin)   yReg <= busVal;
         if (Zin)   zReg <= aluVal;
         if (HIin)  hiReg <= busVal;
         if (LOin)  loReg <= busVal;
         if (rin != 16'h0) regs[oneHotIdx(rin)] <= busVal;
      end
   end

   // Counts a comparison and reports it when the observed value differs.
   task automatic checkOutput(input string tag, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Runs one instruction from its T0 to the next T0 (or to IDLE/HALT),
   // logging outputs per cycle, stalling memory and optionally dropping run.
   task automatic applyStimulus(input int stall, input int dropRunAt, output int lat);
      int guard;
      int c;
      int stallLeft;
      stallLeft = stall;
      readCyc = 0; t1Match = 0; irinCnt = 0; illegalCnt = 0;
      writeCnt = 0; violations = 0;
      guard = 0;
      while (!(PCout && MARin) && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("fetch_start", {63'h0, PCout && MARin}, 64'h1);
      c = 0;
      do begin
         if (c < 32) begin
            logStrobe[c]  = strobes;
            logRout[c]    = rout;
            logRin[c]     = rin;
            logOp[c]      = opcode;
            logIllegal[c] = illegal;
         end
         if (Read) readCyc++;
         if (strobes == T1_PAT) t1Match++;
         if (IRin) irinCnt++;
         if (illegal) illegalCnt++;
         if (rin != 16'h0 || HIin || LOin) writeCnt++;
         if (!$onehot0(rout) || !$onehot0(rin)) violations++;
         if (rout != 16'h0 && (ZLowOut || ZHighOut || MDRout || PCout)) violations++;
         if (Read && !PCin) violations++;
         if (opcode != 5'b0 && !Zin) violations++;
         if (!busy) violations++;
         if (Read && stallLeft > 0) begin
            memReady = 1'b0;
            stallLeft--;
         end else begin
            memReady = 1'b1;
         end
         if (c == dropRunAt) run = 1'b0;
         @(negedge clk);
         c++;
      end while (!(PCout && MARin) && busy && c < 40);
      lat = c;
   endtask

   initial begin
      int lat;
      int guard;
      int bad;
      mem[0] = {5'b00010, 4'd0, 4'd4, 4'd5, 15'd0};
      mem[1] = {5'b00010, 4'd1, 4'd4, 4'd5, 15'd0};
      mem[2] = {5'b01010, 4'd2, 4'd3, 4'd0, 15'd0};
      mem[3] = {5'b01100, 4'd6, 4'd4, 4'd0, 15'd0};
      mem[4] = {5'b11010, 4'd0, 4'd0, 4'd0, 15'd0};
      mem[5] = {5'b11111, 4'd7, 4'd4, 4'd5, 15'd0};
      mem[6] = {5'b00011, 4'd9, 4'd4, 4'd5, 15'd0};
      mem[7] = {5'b00011, 4'd10, 4'd4, 4'd5, 15'd0};
      mem[8] = {5'b11011, 4'd0, 4'd0, 4'd0, 15'd0};
      for (int i = 9; i < 16; i++) mem[i] = 32'h0;

      clr = 1'b0; run = 1'b0; memReady = 1'b1; preload = 1'b1;
      #12;
      checkOutput("reset_outputs", {10'h0, allOut}, 64'h0);
      @(negedge clk);
      @(negedge clk);
      preload = 1'b0;
      clr = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checkOutput("idle_no_run", {10'h0, allOut}, 64'h0);

      $display("[TB] binary sub R0 = R4 - R5");
      run = 1'b1;
      applyStimulus(0, -1, lat);
      checkOutput("sub_lat", lat, 6);
      checkOutput("sub_t0", logStrobe[0], T0_PAT);
      checkOutput("sub_t0_op", logOp[0], 5'b00011);
      checkOutput("sub_t1", logStrobe[1], T1_PAT);
      checkOutput("sub_t2", logStrobe[2], T2_PAT);
      checkOutput("sub_t3", logStrobe[3], B_YIN);
      checkOutput("sub_t3_rout", logRout[3], 16'h0010);
      checkOutput("sub_t4", logStrobe[4], B_ZIN);
      checkOutput("sub_t4_rout", logRout[4], 16'h0020);
      checkOutput("sub_t4_op", logOp[4], 5'b00010);
      checkOutput("sub_t5", logStrobe[5], B_ZLOW);
      checkOutput("sub_t5_rin", logRin[5], 16'h0001);
      checkOutput("sub_rules", violations, 0);
      checkOutput("sub_r0", regs[0], 32'hFFFF_FFF0);

      $display("[TB] binary sub with 3-cycle memory stall");
      applyStimulus(3, -1, lat);
      checkOutput("stall_lat", lat, 9);
      checkOutput("stall_read_cycles", readCyc, 4);
      checkOutput("stall_t1_pattern", t1Match, 4);
      checkOutput("stall_irin_once", irinCnt, 1);
      checkOutput("stall_rules", violations, 0);
      checkOutput("stall_r1", regs[1], 32'hFFFF_FFF0);

      $display("[TB] mul R2 * R3");
      applyStimulus(0, -1, lat);
      checkOutput("mul_lat", lat, 7);
      checkOutput("mul_t3", logStrobe[3], B_YIN);
      checkOutput("mul_t3_rout", logRout[3], 16'h0004);
      checkOutput("mul_t4_rout", logRout[4], 16'h0008);
      checkOutput("mul_t4_op", logOp[4], 5'b01010);
      checkOutput("mul_t5", logStrobe[5], B_ZLOW | B_LOIN);
      checkOutput("mul_t6", logStrobe[6], B_ZHIGH | B_HIIN);
      checkOutput("mul_lo", loReg, 32'hFFFF_FFE0);
      checkOutput("mul_hi", hiReg, 32'hFFFF_FFFF);

      $display("[TB] unary neg R6 = -R4");
      applyStimulus(0, -1, lat);
      checkOutput("neg_lat", lat, 5);
      checkOutput("neg_t3", logStrobe[3], B_ZIN);
      checkOutput("neg_t3_op", logOp[3], 5'b01100);
      checkOutput("neg_t4_rin", logRin[4], 16'h0040);
      checkOutput("neg_r6", regs[6], 32'hFFFF_FFF0);

      $display("[TB] nop");
      applyStimulus(0, -1, lat);
      checkOutput("nop_lat", lat, 4);
      checkOutput("nop_t3", {logStrobe[3], logRout[3]}, 30'h0);

      $display("[TB] undefined opcode 11111");
      applyStimulus(0, -1, lat);
      checkOutput("undef_lat", lat, 4);
      checkOutput("undef_illegal_count", illegalCnt, 1);
      checkOutput("undef_illegal_t3", logIllegal[3], 1'b1);
      checkOutput("undef_no_writes", writeCnt, 0);

      $display("[TB] add with run dropped mid-instruction");
      applyStimulus(0, 1, lat);
      checkOutput("drop_lat", lat, 6);
      checkOutput("drop_r9", regs[9], 32'd48);
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         if (busy || strobes != 14'h0) bad++;
         @(negedge clk);
      end
      checkOutput("drop_stays_idle", bad, 0);

      $display("[TB] asynchronous reset during T4 of an add");
      run = 1'b1;
      guard = 0;
      while (!(PCout && MARin) && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      repeat (4) @(negedge clk);
      checkOutput("rst_pre_t4", strobes, B_ZIN);
      #1 clr = 1'b0;
      #1 checkOutput("rst_async_outputs", {10'h0, allOut}, 64'h0);
      @(negedge clk);
      checkOutput("rst_held_outputs", {10'h0, allOut}, 64'h0);
      checkOutput("rst_r10_unchanged", regs[10], 32'h0);
      clr = 1'b1;

      $display("[TB] halt");
      applyStimulus(0, -1, lat);
      checkOutput("halt_lat", lat, 4);
      checkOutput("halt_flag", {halted, busy}, 2'b10);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (!halted || busy || strobes != 14'h0 || rin != 16'h0 || rout != 16'h0) bad++;
         @(negedge clk);
      end
      checkOutput("halt_quiet_20", bad, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Guard against a stuck run.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
